add: RTL and testbench

- 4-bit unsigned ripple-carry adder. The sum path `{cout, out}` is purely combinational, with zero-cycle latency from the operands.
- A small clocked side block keeps a registered copy of the last sum and a saturating count of carry-out events, for status and debug.
- Sits in the datapath wherever a 4-bit add with carry-out is needed.
- The combinational path must be correct for every operand pair, independent of clock or reset.

---
 rtl/add_pkg.sv | 6 +
 rtl/add_full_adder.sv | 11 +
 rtl/add.sv | 38 +++
 tb/tb_add.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// add_pkg: shared default widths for the 4-bit adder slice
package add_pkg;
  localparam int ADD_WIDTH = 4;
  localparam int ADD_CNT_W = 8;
  localparam logic [ADD_CNT_W-1:0] CNT_MAX = {ADD_CNT_W{1'b1}};
endpackage

// File: rtl/add_full_adder.sv
// full_adder: single-bit full adder stage of the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add.sv
// add: ripple-carry adder with registered sum copy and saturating carry-event counter
module add
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = ADD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic [WIDTH:0]   sum_q,
  output logic [CNT_W-1:0] carry_cnt
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (num1[i]),
      .b   (num2[i]),
      .cin (c[i]),
      .s   (out[i]),
      .cout(c[i+1])
    );
  end
  assign cout = c[WIDTH];
  // Status registers only; the sum path above never sees clk or rst.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q     <= '0;
      carry_cnt <= '0;
    end else begin
      sum_q     <= {cout, out};
      carry_cnt <= (cout && carry_cnt != {CNT_W{1'b1}}) ? carry_cnt + 1'b1 : carry_cnt;
    end
endmodule

// File: tb/tb_add.sv
// tb_add: self-checking bench for add (exhaustive, corners, reset, counter, random)
module tb_add;
  import add_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] num1 = '0;
  logic [3:0] num2 = '0;
  logic [3:0] out;
  logic       cout;
  logic [4:0] sum_q;
  logic [7:0] carry_cnt;
  int n_chk = 0;
  int n_fail = 0;

  add dut (
    .clk      (clk),
    .rst      (rst),
    .num1     (num1),
    .num2     (num2),
    .out      (out),
    .cout     (cout),
    .sum_q    (sum_q),
    .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[9];
    int mcnt;
    int ma, mb;
    logic [4:0] msq;
    vt[0] = '{4'd0,  4'd0,  5'b0_0000};
    vt[1] = '{4'd15, 4'd15, 5'b1_1110};
    vt[2] = '{4'd15, 4'd1,  5'b1_0000};
    vt[3] = '{4'd1,  4'd15, 5'b1_0000};
    vt[4] = '{4'd8,  4'd8,  5'b1_0000};
    vt[5] = '{4'd7,  4'd8,  5'b0_1111};
    vt[6] = '{4'd8,  4'd7,  5'b0_1111};
    vt[7] = '{4'd9,  4'd6,  5'b0_1111};
    vt[8] = '{4'd12, 4'd5,  5'b1_0001};

    #2;
    chk("reset_sum_q", 32'(sum_q), 0);
    chk("reset_carry_cnt", 32'(carry_cnt), 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        num1 = 4'(a);
        num2 = 4'(b);
        #1;
        chk($sformatf("sweep_%0d_%0d", a, b), 32'({cout, out}), 32'(a + b));
      end

    for (int i = 0; i < 9; i++) begin
      num1 = vt[i].a;
      num2 = vt[i].b;
      #1;
      chk($sformatf("corner_%0d_%0d", vt[i].a, vt[i].b), 32'({cout, out}), 32'(vt[i].exp));
    end

    @(negedge clk);
    rst = 1'b0;
    num1 = 4'd15;
    num2 = 4'd15;
    repeat (3) tick();
    chk("pre_rst_sum_q", 32'(sum_q), 32'h1e);
    chk("pre_rst_carry_cnt", 32'(carry_cnt), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sum_q", 32'(sum_q), 0);
    chk("async_rst_carry_cnt", 32'(carry_cnt), 0);
    chk("rst_out", 32'(out), 14);
    chk("rst_cout", 32'(cout), 1);
    #1;
    rst = 1'b0;
    num1 = 4'd3;
    num2 = 4'd4;
    #1;
    chk("latency_before_edge", 32'(sum_q), 0);
    tick();
    chk("latency_after_edge", 32'(sum_q), 32'h07);
    chk("latency_carry_cnt", 32'(carry_cnt), 0);

    num1 = 4'd10;
    num2 = 4'd10;
    repeat (5) tick();
    chk("cnt_after_5", 32'(carry_cnt), 5);
    num1 = 4'd1;
    num2 = 4'd1;
    repeat (3) tick();
    chk("cnt_hold", 32'(carry_cnt), 5);
    chk("cnt_hold_sum_q", 32'(sum_q), 32'h02);

    num1 = 4'd15;
    num2 = 4'd15;
    repeat (300) tick();
    chk("cnt_saturate", 32'(carry_cnt), 32'(CNT_MAX));
    repeat (2) tick();
    chk("cnt_no_wrap", 32'(carry_cnt), 255);

    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mcnt = 0;
    for (int k = 0; k < 300; k++) begin
      ma = int'($urandom_range(15, 0));
      mb = int'($urandom_range(15, 0));
      num1 = 4'(ma);
      num2 = 4'(mb);
      #1;
      chk("rand_comb", 32'({cout, out}), 32'(ma + mb));
      tick();
      msq = 5'(ma + mb);
      if (ma + mb > 15) mcnt = (mcnt + 1 > 255) ? 255 : mcnt + 1;
      chk("rand_sum_q", 32'(sum_q), 32'(msq));
      chk("rand_carry_cnt", 32'(carry_cnt), 32'(mcnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
